// File: rtl/sgdmac_pkg.sv
// Shared SGDMAC types: the return-path destination encoding used by the arbiter
// and the dispatcher, plus the default tag FIFO depth.
package sgdmac_pkg;

  typedef enum logic {
    DST_DESC = 1'b0,
    DST_DATA = 1'b1
  } dst_sel_e;

  localparam int TAG_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sgdmac_tag_fifo.sv
// In-order FIFO of 1-bit grant tags. full/empty/count come from registered
// occupancy, so a push becomes visible only after the next clock edge.
module sgdmac_tag_fifo
  import sgdmac_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       din_i,
  input  logic                       pop_i,
  output logic                       dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/sgdmac_dispatcher.sv
// Steers returning read bursts to the descriptor fetcher or data reader using
// the in-order grant tags. Optional error checking: SGDMAC_DISPATCHER_ERR_EN.
module sgdmac_dispatcher
  import sgdmac_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int TAG_DEPTH = TAG_DEPTH_DEFAULT,
  parameter int MAX_BEATS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tag_push_i,
  input  logic                           tag_sel_i,
  output logic                           tag_full_o,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding_o,
  input  logic                           src_valid_i,
  output logic                           src_ready_o,
  input  logic [DATA_SIZE-1:0]           src_data_i,
  input  logic                           src_last_i,
  output logic                           descriptor_valid_o,
  input  logic                           descriptor_ready_i,
  output logic [DATA_SIZE-1:0]           descriptor_data_o,
  output logic                           descriptor_last_o,
  output logic                           data_reader_valid_o,
  input  logic                           data_reader_ready_i,
  output logic [DATA_SIZE-1:0]           data_reader_data_o,
  output logic                           data_reader_last_o,
  output logic                           err_o
);

  if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0 || MAX_BEATS < 1) begin : g_bad_cfg
    $error("sgdmac_dispatcher: TAG_DEPTH must be a power of two >= 2, MAX_BEATS >= 1");
  end

  logic                 fifo_empty, fifo_head;
  dst_sel_e             head_sel;
  logic                 drain, accept, pop;
  logic                 out_valid_q, out_valid_d;
  dst_sel_e             out_sel_q, out_sel_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;

  sgdmac_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_push_i),
    .din_i   (tag_sel_i),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (tag_full_o),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  assign head_sel = dst_sel_e'(fifo_head);

  // Output slot is free when empty or when its consumer takes it this cycle.
  assign drain = ~out_valid_q |
                 ((out_sel_q == DST_DATA) ? data_reader_ready_i : descriptor_ready_i);
  assign src_ready_o = ~fifo_empty & drain;
  assign accept      = src_valid_i & src_ready_o;
  assign pop         = accept & src_last_i;

  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sel_d   = head_sel;
      out_data_d  = src_data_i;
      out_last_d  = src_last_i;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= DST_DESC;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign descriptor_valid_o  = out_valid_q & (out_sel_q == DST_DESC);
  assign data_reader_valid_o = out_valid_q & (out_sel_q == DST_DATA);
  assign descriptor_data_o   = out_data_q;
  assign descriptor_last_o   = out_last_q;
  assign data_reader_data_o  = out_data_q;
  assign data_reader_last_o  = out_last_q;

`ifdef SGDMAC_DISPATCHER_ERR_EN
  localparam int BCW = $clog2(MAX_BEATS + 1);

  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic           err_q, err_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (accept) begin
      if (src_last_i) begin
        beat_cnt_d = '0;
      end else begin
        // Saturate so an overlong burst cannot wrap the counter back to legal.
        if (beat_cnt_q < BCW'(MAX_BEATS)) beat_cnt_d = beat_cnt_q + BCW'(1);
        if (beat_cnt_q + BCW'(1) == BCW'(MAX_BEATS)) err_d = 1'b1;
      end
    end
    if (tag_push_i & tag_full_o) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sgdmac_dispatcher.sv
// Directed bench for sgdmac_dispatcher: a vector table for basic routing and
// empty-FIFO stalls, plus hand sequences for backpressure, full, and reset.
module tb_sgdmac_dispatcher;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          tag_push, tag_sel, tag_full;
  logic [2:0]    outstanding;
  logic          src_valid, src_ready, src_last;
  logic [DW-1:0] src_data;
  logic          desc_valid, desc_ready, desc_last;
  logic [DW-1:0] desc_data;
  logic          dr_valid, dr_ready, dr_last;
  logic [DW-1:0] dr_data;
  logic          err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sgdmac_dispatcher #(.DATA_SIZE(DW), .TAG_DEPTH(4), .MAX_BEATS(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .tag_push_i          (tag_push),
    .tag_sel_i           (tag_sel),
    .tag_full_o          (tag_full),
    .outstanding_o       (outstanding),
    .src_valid_i         (src_valid),
    .src_ready_o         (src_ready),
    .src_data_i          (src_data),
    .src_last_i          (src_last),
    .descriptor_valid_o  (desc_valid),
    .descriptor_ready_i  (desc_ready),
    .descriptor_data_o   (desc_data),
    .descriptor_last_o   (desc_last),
    .data_reader_valid_o (dr_valid),
    .data_reader_ready_i (dr_ready),
    .data_reader_data_o  (dr_data),
    .data_reader_last_o  (dr_last),
    .err_o               (err)
  );

  typedef struct {
    logic          push, sel, sval, slast, drdy, rrdy;
    logic [DW-1:0] sdata;
    logic          e_srdy, e_dv, e_rv, e_last;
    logic [DW-1:0] e_data;
    logic [2:0]    e_out;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic push, logic sel, logic sval, logic [DW-1:0] sdata,
                              logic slast, logic e_srdy, logic e_dv, logic e_rv,
                              logic [DW-1:0] e_data, logic e_last, logic [2:0] e_out);
    vec_t v;
    v.push = push; v.sel = sel; v.sval = sval; v.sdata = sdata; v.slast = slast;
    v.drdy = 1'b1; v.rrdy = 1'b1;
    v.e_srdy = e_srdy; v.e_dv = e_dv; v.e_rv = e_rv;
    v.e_data = e_data; v.e_last = e_last; v.e_out = e_out;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tag_push = 0; tag_sel = 0; src_valid = 0; src_data = '0; src_last = 0;
  endtask

  logic exp_err;

  initial begin
    rst = 1'b1;
    idle_inputs();
    desc_ready = 1; dr_ready = 1;
`ifdef SGDMAC_DISPATCHER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // push, sel, sval, sdata, slast | srdy, dv, rv, data, last, outstanding
    vecs[0] = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0);
    vecs[1] = mk(1, 1, 1, 32'hAAAA0001, 0, 1, 0, 0, 32'h0,        0, 1);
    vecs[2] = mk(0, 0, 1, 32'hBBBB0002, 1, 1, 1, 0, 32'hAAAA0001, 0, 2);
    vecs[3] = mk(0, 0, 1, 32'hCCCC0003, 1, 1, 1, 0, 32'hBBBB0002, 1, 1);
    vecs[4] = mk(0, 0, 0, 32'h0,        0, 0, 0, 1, 32'hCCCC0003, 1, 0);
    vecs[5] = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'hCCCC0003, 1, 0);
    vecs[6] = mk(0, 0, 1, 32'hDDDD0004, 1, 0, 0, 0, 32'hCCCC0003, 1, 0);
    vecs[7] = mk(1, 0, 1, 32'hDDDD0004, 1, 0, 0, 0, 32'hCCCC0003, 1, 0);
    vecs[8] = mk(0, 0, 1, 32'hDDDD0004, 1, 1, 0, 0, 32'hCCCC0003, 1, 1);
    vecs[9] = mk(0, 0, 0, 32'h0,        0, 0, 1, 0, 32'hDDDD0004, 1, 0);

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_desc_valid", desc_valid, 0);
    chk("rst_dr_valid", dr_valid, 0);
    chk("rst_full", tag_full, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_data", {desc_data, dr_data}, 64'h0);
    chk("rst_last", {desc_last, dr_last}, 2'b00);
    tick();

    for (int i = 0; i < 10; i++) begin
      tag_push = vecs[i].push; tag_sel = vecs[i].sel;
      src_valid = vecs[i].sval; src_data = vecs[i].sdata; src_last = vecs[i].slast;
      desc_ready = vecs[i].drdy; dr_ready = vecs[i].rrdy;
      @(negedge clk);
      chk($sformatf("v%0d_src_ready", i), src_ready, vecs[i].e_srdy);
      chk($sformatf("v%0d_desc_valid", i), desc_valid, vecs[i].e_dv);
      chk($sformatf("v%0d_dr_valid", i), dr_valid, vecs[i].e_rv);
      chk($sformatf("v%0d_desc_data", i), desc_data, vecs[i].e_data);
      chk($sformatf("v%0d_dr_data", i), dr_data, vecs[i].e_data);
      chk($sformatf("v%0d_last", i), {desc_last, dr_last}, {vecs[i].e_last, vecs[i].e_last});
      chk($sformatf("v%0d_outstanding", i), outstanding, vecs[i].e_out);
      tick();
    end
    idle_inputs();

    // Backpressure on the data reader while descriptor stays ready
    tag_push = 1; tag_sel = 1; desc_ready = 1; dr_ready = 0;
    tick();
    tag_push = 0; src_valid = 1; src_data = 32'hEEEE0005; src_last = 0;
    @(negedge clk);
    chk("bp_accept_e", src_ready, 1);
    tick();
    src_data = 32'hFFFF0006; src_last = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_dr_valid", c), dr_valid, 1);
      chk($sformatf("bp%0d_dr_data", c), dr_data, 32'hEEEE0005);
      chk($sformatf("bp%0d_src_ready", c), src_ready, 0);
      chk($sformatf("bp%0d_desc_valid", c), desc_valid, 0);
      tick();
    end
    dr_ready = 1;
    @(negedge clk);
    chk("bp_release_src_ready", src_ready, 1);
    tick();
    src_valid = 0;
    @(negedge clk);
    chk("bp_f_data", dr_data, 32'hFFFF0006);
    chk("bp_f_valid_last", {dr_valid, dr_last}, 2'b11);
    chk("bp_outstanding", outstanding, 0);
    tick();

    // Fill the tag FIFO, then overflow it
    idle_inputs();
    tag_push = 1;
    repeat (4) tick();
    @(negedge clk);
    chk("full_flag", tag_full, 1);
    chk("full_outstanding", outstanding, 4);
    tick();
    tag_push = 0;
    @(negedge clk);
    chk("overflow_outstanding", outstanding, 4);
    chk("overflow_err", err, exp_err);
    tick();
    src_valid = 1; src_data = 32'h11110007; src_last = 1;
    @(negedge clk);
    chk("full_drain_ready", src_ready, 1);
    tick();
    src_valid = 0;
    @(negedge clk);
    chk("freed_outstanding", outstanding, 3);
    chk("freed_full", tag_full, 0);
    chk("freed_desc", {desc_valid, desc_data}, {1'b1, 32'h11110007});
    tick();

    // Bring occupancy to 2, then push and pop together
    src_valid = 1; src_data = 32'h22220008; src_last = 1;
    tick();
    src_valid = 0;
    @(negedge clk);
    chk("pp_pre_outstanding", outstanding, 2);
    tick();
    tag_push = 1; tag_sel = 0;
    src_valid = 1; src_data = 32'h33330009; src_last = 1;
    @(negedge clk);
    chk("pp_src_ready", src_ready, 1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("pp_outstanding", outstanding, 2);
    chk("pp_desc", {desc_valid, desc_data}, {1'b1, 32'h33330009});
    tick();

    // Asynchronous reset with a beat held in the output register
    src_valid = 1; src_data = 32'h4444000A; src_last = 0;
    tick();
    src_valid = 0;
    @(negedge clk);
    chk("mid_held_valid", desc_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_valids", {desc_valid, dr_valid}, 2'b00);
    chk("arst_outstanding", outstanding, 0);
    chk("arst_full", tag_full, 0);
    chk("arst_src_ready", src_ready, 0);
    chk("arst_err", err, 0);
    chk("arst_data", desc_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tag_push = 1; tag_sel = 1;
    tick();
    tag_push = 0; src_valid = 1; src_data = 32'h5555000B; src_last = 1;
    @(negedge clk);
    chk("post_rst_src_ready", src_ready, 1);
    tick();
    src_valid = 0;
    @(negedge clk);
    chk("post_rst_dr", {dr_valid, dr_last, dr_data}, {2'b11, 32'h5555000B});
    chk("post_rst_desc_valid", desc_valid, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
